soc_bram_ctl2: RTL and testbench
================================

# soc_bram_ctl2

Second-generation on-chip block-RAM controller for the SoC bus. It serves two independent requesters (channel A and channel B) from one single-port inferred BRAM. Data width, depth and read latency are parameters, and writes use per-byte write strobes. Each channel uses the existing valid/ready request handshake. A round-robin arbiter resolves simultaneous requests.

## Interface
- `addr_width`, default 12: byte-address width; depth = 2^(addr_width − lsb) words, where lsb = log2(data_width/8).
- `data_width`, default 32: word width; must be a multiple of 8 and ≥ 16.
- `rd_latency`, default 1: 1 = BRAM output used directly; 2 = extra output register stage. Other values are illegal and checked at elaboration.

Ports:
- `clk`  in  1  single clock; all logic on posedge.
- `rstn`  in  1  asynchronous, active-low reset.
- `valid_a` / `valid_b`  in  1  request pending on channel A / B.
- `rw_a` / `rw_b`  in  1  1 = write, 0 = read.
- `addr_a` / `addr_b`  in  addr_width  byte address; low lsb bits are ignored.
- `dwrite_a` / `dwrite_b`  in  data_width  write data.
- `wmask_a` / `wmask_b`  in  data_width/8  byte write strobes; bit i enables byte i. Ignored on reads.
- `ready_a` / `ready_b`  out  1  one-cycle completion pulse.
- `dread_a` / `dread_b`  out  data_width  read data for the channel; valid while that channel's ready is high.
- `busy`  out  1  high whenever the FSM is not in IDLE.

## Operation
- FSM states:
  - IDLE: if any valid is high, grant one channel, latch its addr/rw/dwrite/wmask into request registers, and go to ACCESS.
  - ACCESS: one BRAM cycle. For a write, each byte i with wmask[i]=1 is written; other bytes are unchanged. For a read, the BRAM output register loads the word. Next state is DONE if rd_latency=1 or the access is a write; otherwise WAIT.
  - WAIT: the output register stage loads. Next state is DONE.
  - DONE: ready of the granted channel is high. For a read, that channel's dread holds the word. Next state is IDLE.
- Arbitration:
  - Only one valid high: that channel wins.
  - Both valid high: the channel not granted last time wins.
  - last_grant resets to B, so A wins the first tie.
  - A grant is never revoked mid-access.
- Requester rules:
  - Hold valid, addr, rw, dwrite and wmask stable until ready.
  - Deasserting valid before ready is illegal; the controller has already latched the request and completes it regardless.
  - The requester may keep valid high after ready to issue a back-to-back request. That request is sampled in the next IDLE.
- dread_x updates only on completion of a read granted to channel x. It holds its value across writes and across the other channel's accesses.
- Word index = addr[addr_width−1:lsb]. A misaligned address aliases to the containing word; no error is raised.
- Memory contents are not reset and not initialised, except by an optional simulation-only `$readmemh` when `BRAM_INIT` is defined.

## Timing
- Reset values: ready_a = ready_b = 0, dread_a = dread_b = 0, busy = 0, state = IDLE, last_grant = B.
- Edge E0 = posedge where IDLE samples valid high.
  - Write: the BRAM write occurs at E1. ready is high from E1 to E2.
  - Read with rd_latency=1: data is registered at E1. ready and dread are valid from E1 to E2.
  - Read with rd_latency=2: ready is high from E2 to E3.
  - IDLE is re-entered at the edge where ready falls, and a new request can be sampled at that same edge.
- Throughput:
  - 2 cycles per access, for writes and for reads with rd_latency=1.
  - 3 cycles per read with rd_latency=2.
- Latency is fixed; there are no wait states beyond those listed.
- While one channel is served, the other channel's valid is ignored; it is arbitrated at the next IDLE.
- Reset mid-operation: all state returns to reset values immediately.
  - A write whose ACCESS edge has not yet occurred is dropped.
  - An in-flight read produces no ready.
  - After rstn rises, the first sampling edge behaves as E0.

## Test plan
- Channel A writes 0x1122_3344 to 0x20 with wmask 4'hF, then 0x5566_7788 to 0x24. Channel A then reads 0x24 → dread_a = 0x5566_7788 with ready_a high exactly 1 cycle, 1 cycle after sampling.
- After the above, A writes 0xAABB_CCDD to 0x20 with wmask 4'b0010 → a read of 0x20 returns 0x1122_CC44.
- valid_a and valid_b both held high from reset with different reads → grants in order A, B, A, B, each ready 2 cycles apart. dread_b is unchanged during A's completions.
- rd_latency=2 instance: read 0x24 → ready 2 cycles after sampling, 3-cycle throughput. Writes remain at 1-cycle ready latency.
- Read of 0x23 → returns the word at 0x20.
- A write to 0x40 is sampled, and rstn is pulsed low before the ACCESS edge → no ready, busy = 0. A subsequent read of 0x40 does not return the dropped data, i.e. returns the value written earlier.

Source files
------------

// File: rtl/soc_bram_ctl2.sv
// Dual-channel controller for a single-port inferred block RAM.
// Channels A and B share the RAM through a round-robin arbiter.
// Each access is latched once and then runs for a fixed number of cycles.
//
// state  | meaning
// -------+----------------------------------------------------------
// IDLE   | nothing in flight; a pending valid is granted and latched
// ACCESS | single RAM cycle: byte-masked write, or read into mem_q
// WAIT   | read data moves into the extra output stage (rd_latency=2)
// DONE   | ready pulse for the granted channel; may grant the next request
module soc_bram_ctl2 #(
    parameter int addr_width = 12,
    parameter int data_width = 32,
    parameter int rd_latency = 1
) (
    input  logic                    clk,
    input  logic                    rstn,
    input  logic                    valid_a,
    input  logic                    rw_a,
    input  logic [addr_width-1:0]   addr_a,
    input  logic [data_width-1:0]   dwrite_a,
    input  logic [data_width/8-1:0] wmask_a,
    output logic                    ready_a,
    output logic [data_width-1:0]   dread_a,
    input  logic                    valid_b,
    input  logic                    rw_b,
    input  logic [addr_width-1:0]   addr_b,
    input  logic [data_width-1:0]   dwrite_b,
    input  logic [data_width/8-1:0] wmask_b,
    output logic                    ready_b,
    output logic [data_width-1:0]   dread_b,
    output logic                    busy
);
    localparam int nbytes = data_width / 8;
    localparam int lsb    = $clog2(nbytes);
    localparam int depth  = 1 << (addr_width - lsb);

    if (rd_latency != 1 && rd_latency != 2) begin : g_bad_latency
        $error("soc_bram_ctl2: rd_latency must be 1 or 2");
    end
    if (data_width % 8 != 0 || data_width < 16) begin : g_bad_width
        $error("soc_bram_ctl2: data_width must be a multiple of 8 and >= 16");
    end

    typedef enum logic [1:0] {IDLE, ACCESS, WAIT, DONE} state_t;

    state_t                       state, state_nx;
    logic                         gnt_b;
    logic                         last_b;
    logic                         req_rw;
    logic [addr_width-lsb-1:0]    req_idx;
    logic [data_width-1:0]        req_data;
    logic [nbytes-1:0]            req_mask;
    logic [data_width-1:0]        mem [depth];
    logic [data_width-1:0]        mem_q;
    logic [data_width-1:0]        pipe_q;
    logic [data_width-1:0]        rd_data;
    logic [data_width-1:0]        dread_a_q;
    logic [data_width-1:0]        dread_b_q;
    logic                         any_valid;
    logic                         take;
    logic                         pick_b;
    logic                         unused_addr_bits;

    // Byte offset bits do not select a word; misaligned addresses alias.
    assign unused_addr_bits = ^{addr_a[lsb-1:0], addr_b[lsb-1:0]};

    assign any_valid = valid_a | valid_b;
    // B wins only if A is idle, or on a tie when A was granted last.
    assign pick_b    = valid_b & (~valid_a | ~last_b);
    // DONE exits straight into a new grant so back-to-back accesses take 2 cycles.
    assign take      = any_valid & ((state == IDLE) | (state == DONE));

    // Next-state logic.
    always_comb begin
        state_nx = state;
        case (state)
            IDLE:    if (any_valid) state_nx = ACCESS;
            ACCESS:  state_nx = (req_rw || rd_latency == 1) ? DONE : WAIT;
            WAIT:    state_nx = DONE;
            DONE:    state_nx = any_valid ? ACCESS : IDLE;
            default: state_nx = IDLE;
        endcase
    end

    // State, arbitration history, request latch and per-channel read holders.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            state     <= IDLE;
            gnt_b     <= 1'b0;
            last_b    <= 1'b1;
            req_rw    <= 1'b0;
            req_idx   <= '0;
            req_data  <= '0;
            req_mask  <= '0;
            dread_a_q <= '0;
            dread_b_q <= '0;
        end else begin
            state <= state_nx;
            if (state == DONE && !req_rw) begin
                if (gnt_b) dread_b_q <= rd_data;
                else       dread_a_q <= rd_data;
            end
            if (take) begin
                gnt_b    <= pick_b;
                last_b   <= pick_b;
                req_rw   <= pick_b ? rw_b : rw_a;
                req_idx  <= pick_b ? addr_b[addr_width-1:lsb] : addr_a[addr_width-1:lsb];
                req_data <= pick_b ? dwrite_b : dwrite_a;
                req_mask <= pick_b ? wmask_b : wmask_a;
            end
        end
    end

    // RAM array: byte-masked write or registered read, only in ACCESS.
    always_ff @(posedge clk) begin
        if (state == ACCESS) begin
            if (req_rw) begin
                for (int i = 0; i < nbytes; i++) begin
                    if (req_mask[i]) mem[req_idx][8*i +: 8] <= req_data[8*i +: 8];
                end
            end else begin
                mem_q <= mem[req_idx];
            end
        end
    end

    // Optional second output register stage.
    always_ff @(posedge clk) begin
        if (state == WAIT) pipe_q <= mem_q;
    end

    assign rd_data = (rd_latency == 1) ? mem_q : pipe_q;

    assign ready_a = (state == DONE) & ~gnt_b;
    assign ready_b = (state == DONE) & gnt_b;
    assign dread_a = (ready_a && !req_rw) ? rd_data : dread_a_q;
    assign dread_b = (ready_b && !req_rw) ? rd_data : dread_b_q;
    assign busy    = (state != IDLE);

endmodule

// File: tb/tb_soc_bram_ctl2.sv
// Bench for soc_bram_ctl2: one instance per read latency, each checked
// against a word-array memory model and per-channel read-data holders.
module tb_soc_bram_ctl2;
    logic        clk = 1'b0;
    logic        rstn     [2];
    logic        valid_a  [2];
    logic        rw_a     [2];
    logic [11:0] addr_a   [2];
    logic [31:0] dwrite_a [2];
    logic [3:0]  wmask_a  [2];
    logic        ready_a  [2];
    logic [31:0] dread_a  [2];
    logic        valid_b  [2];
    logic        rw_b     [2];
    logic [11:0] addr_b   [2];
    logic [31:0] dwrite_b [2];
    logic [3:0]  wmask_b  [2];
    logic        ready_b  [2];
    logic [31:0] dread_b  [2];
    logic        busy     [2];

    logic [31:0] mem_m   [2][1024];
    logic [31:0] dread_m [2][2];

    int checks   = 0;
    int failures = 0;

    always #5 clk = ~clk;

    for (genvar g = 0; g < 2; g++) begin : g_dut
        soc_bram_ctl2 #(.addr_width(12), .data_width(32), .rd_latency(g + 1)) u_dut (
            .clk(clk), .rstn(rstn[g]),
            .valid_a(valid_a[g]), .rw_a(rw_a[g]), .addr_a(addr_a[g]),
            .dwrite_a(dwrite_a[g]), .wmask_a(wmask_a[g]),
            .ready_a(ready_a[g]), .dread_a(dread_a[g]),
            .valid_b(valid_b[g]), .rw_b(rw_b[g]), .addr_b(addr_b[g]),
            .dwrite_b(dwrite_b[g]), .wmask_b(wmask_b[g]),
            .ready_b(ready_b[g]), .dread_b(dread_b[g]),
            .busy(busy[g])
        );
    end

    task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        if (obs !== exp) begin
            failures++;
            $display("FAIL %s: got %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic set_req(input int d, input bit ch, input bit v, input bit rw,
                           input logic [11:0] a, input logic [31:0] dt, input logic [3:0] m);
        if (!ch) begin
            valid_a[d] = v; rw_a[d] = rw; addr_a[d] = a; dwrite_a[d] = dt; wmask_a[d] = m;
        end else begin
            valid_b[d] = v; rw_b[d] = rw; addr_b[d] = a; dwrite_b[d] = dt; wmask_b[d] = m;
        end
    endtask

    // Model: a write merges enabled bytes into the addressed word.
    task automatic model_write(input int d, input logic [11:0] a, input logic [31:0] dt,
                               input logic [3:0] m);
        for (int i = 0; i < 4; i++)
            if (m[i]) mem_m[d][a[11:2]][8*i +: 8] = dt[8*i +: 8];
    endtask

    task automatic do_reset(input int d);
        rstn[d] = 1'b0;
        set_req(d, 1'b0, 1'b0, 1'b0, '0, '0, '0);
        set_req(d, 1'b1, 1'b0, 1'b0, '0, '0, '0);
        @(posedge clk); #1;
        check_eq("rst_busy", 32'(busy[d]), 32'd0);
        check_eq("rst_ready", {30'd0, ready_a[d], ready_b[d]}, 32'd0);
        check_eq("rst_dread_a", dread_a[d], 32'd0);
        check_eq("rst_dread_b", dread_b[d], 32'd0);
        dread_m[d][0] = '0;
        dread_m[d][1] = '0;
        @(negedge clk) rstn[d] = 1'b1;
        @(posedge clk); #1;
    endtask

    // One request from an idle controller; called #1 after a posedge.
    task automatic do_op(input int d, input bit ch, input bit rw, input logic [11:0] a,
                         input logic [31:0] dt, input logic [3:0] m);
        int   n;
        logic rdy;
        set_req(d, ch, 1'b1, rw, a, dt, m);
        n = 0;
        rdy = 1'b0;
        while (!rdy && n < 8) begin
            @(posedge clk); #1;
            n++;
            rdy = ch ? ready_b[d] : ready_a[d];
        end
        check_eq("latency", 32'(n), 32'(rw ? 2 : d + 2));
        check_eq("other_ready", 32'(ch ? ready_a[d] : ready_b[d]), 32'd0);
        if (rw) model_write(d, a, dt, m);
        else    dread_m[d][ch] = mem_m[d][a[11:2]];
        check_eq("dread_own", ch ? dread_b[d] : dread_a[d], dread_m[d][ch]);
        check_eq("dread_other", ch ? dread_a[d] : dread_b[d], dread_m[d][!ch]);
        set_req(d, ch, 1'b0, 1'b0, '0, '0, '0);
        @(posedge clk); #1;
        check_eq("ready_width", 32'(ch ? ready_b[d] : ready_a[d]), 32'd0);
        check_eq("busy_after", 32'(busy[d]), 32'd0);
        check_eq("dread_hold", ch ? dread_b[d] : dread_a[d], dread_m[d][ch]);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1);
    end

    initial begin
        for (int d = 0; d < 2; d++) begin
            rstn[d] = 1'b0;
            set_req(d, 1'b0, 1'b0, 1'b0, '0, '0, '0);
            set_req(d, 1'b1, 1'b0, 1'b0, '0, '0, '0);
        end

        for (int d = 0; d < 2; d++) begin
            do_reset(d);
            do_op(d, 0, 1, 12'h020, 32'h1122_3344, 4'hF);
            do_op(d, 0, 1, 12'h024, 32'h5566_7788, 4'hF);
            do_op(d, 0, 0, 12'h024, '0, '0);
            check_eq("read_24", dread_a[d], 32'h5566_7788);
            do_op(d, 0, 1, 12'h020, 32'hAABB_CCDD, 4'b0010);
            do_op(d, 0, 0, 12'h020, '0, '0);
            check_eq("merge_20", dread_a[d], 32'h1122_CC44);
            do_op(d, 1, 0, 12'h023, '0, '0);
            check_eq("alias_23", dread_b[d], 32'h1122_CC44);
            for (int k = 0; k < 8; k++)
                do_op(d, k[0], 1, 12'h100 + 12'(4 * k), $urandom, 4'hF);
            for (int k = 0; k < 40; k++)
                do_op(d, 1'($urandom), 1'($urandom), 12'h100 + 12'($urandom_range(0, 31)),
                      $urandom, 4'($urandom));
        end

        // Simultaneous reads held from reset: A wins first, then alternation.
        rstn[0] = 1'b0;
        set_req(0, 1'b0, 1'b1, 1'b0, 12'h020, '0, '0);
        set_req(0, 1'b1, 1'b1, 1'b0, 12'h024, '0, '0);
        dread_m[0][0] = '0;
        dread_m[0][1] = '0;
        @(negedge clk) rstn[0] = 1'b1;
        for (int n = 1; n <= 8; n++) begin
            bit ea, eb;
            @(posedge clk); #1;
            ea = (n % 2 == 0) && (((n / 2) - 1) % 2 == 0);
            eb = (n % 2 == 0) && (((n / 2) - 1) % 2 == 1);
            if (ea) dread_m[0][0] = mem_m[0][12'h020 >> 2];
            if (eb) dread_m[0][1] = mem_m[0][12'h024 >> 2];
            check_eq("arb_ready_a", 32'(ready_a[0]), 32'(ea));
            check_eq("arb_ready_b", 32'(ready_b[0]), 32'(eb));
            check_eq("arb_dread_a", dread_a[0], dread_m[0][0]);
            check_eq("arb_dread_b", dread_b[0], dread_m[0][1]);
        end
        set_req(0, 1'b0, 1'b0, 1'b0, '0, '0, '0);
        set_req(0, 1'b1, 1'b0, 1'b0, '0, '0, '0);
        @(posedge clk); #1;
        check_eq("arb_idle", 32'(busy[0]), 32'd0);

        // Write sampled, then reset before its RAM cycle: it must be dropped.
        for (int d = 0; d < 2; d++) begin
            logic [31:0] keep;
            keep = $urandom;
            do_op(d, 0, 1, 12'h040, keep, 4'hF);
            set_req(d, 1'b0, 1'b1, 1'b1, 12'h040, ~keep, 4'hF);
            @(posedge clk); #2;
            rstn[d] = 1'b0;
            set_req(d, 1'b0, 1'b0, 1'b0, '0, '0, '0);
            #1;
            check_eq("drop_busy", 32'(busy[d]), 32'd0);
            @(posedge clk); #1;
            check_eq("drop_ready", 32'(ready_a[d]), 32'd0);
            dread_m[d][0] = '0;
            dread_m[d][1] = '0;
            @(negedge clk) rstn[d] = 1'b1;
            @(posedge clk); #1;
            do_op(d, 0, 0, 12'h040, '0, '0);
            check_eq("drop_kept", dread_a[d], keep);
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
